bus_timer: RTL

- Memory-mapped 32-bit timer peripheral on the CPU data bus, downstream of the RV32I core and alongside the data RAM.
- Consumes the same bus signals the RAM does: write enable, address, write data, 4-bit byte enable. Returns read data to the core.
- Provides a prescaled up-counter, a compare match with a sticky flag, a one-shot or auto-reload mode, and a level interrupt output.

---
 rtl/bus_timer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer peripheral: a prescaled up-counter with a compare
// match, a sticky match flag, one-shot or auto-reload behaviour and a level
// interrupt. Sits on the core data bus next to the data RAM.
module bus_timer #(
  parameter logic [31:0] PSC_RESET = 32'd0,
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wData,
  input  logic [3:0]  Byte_Enable,
  output logic [31:0] rData,
  output logic        irq
);

  // The timer is either stopped or counting; CTRL.EN is the state bit itself.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PSC    = 3'd1;
  localparam logic [2:0] REG_CNT    = 3'd2;
  localparam logic [2:0] REG_CMP    = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] psc_q, psc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic [31:0] pcnt_q, pcnt_d;

  state_e      state;
  logic [2:0]  regSel;
  logic        wrAny;
  logic        wrCtrl, wrPsc, wrCnt, wrCmp, wrStatus;
  logic        tick;
  logic        hit;
  logic        unusedAddrBits;

  // Merge the enabled byte lanes of a bus write into an existing register value.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[8*i +: 8] = be[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
    end
    return result;
  endfunction

  assign state          = ctrl_q[0] ? RUN : IDLE;
  assign regSel         = addr[4:2];
  assign unusedAddrBits = ^addr[1:0];

  // A write with no byte lanes enabled is treated as no write at all, so it
  // neither clears the prescaler nor overrides a tick.
  assign wrAny    = sel & we & (|Byte_Enable);
  assign wrCtrl   = wrAny && (regSel == REG_CTRL);
  assign wrPsc    = wrAny && (regSel == REG_PSC);
  assign wrCnt    = wrAny && (regSel == REG_CNT);
  assign wrCmp    = wrAny && (regSel == REG_CMP);
  assign wrStatus = wrAny && (regSel == REG_STATUS);

  assign tick = (state == RUN) && (pcnt_q == psc_q);
  assign hit  = tick && (cnt_q == cmp_q);

  assign irq = match_q & ctrl_q[2];

  // Next-state logic; bus writes take priority over timer activity.
  always_comb begin
    ctrl_d  = ctrl_q;
    psc_d   = psc_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    pcnt_d  = pcnt_q;

    if (wrCtrl || wrPsc) begin
      pcnt_d = 32'd0;
    end else if (state == RUN) begin
      pcnt_d = tick ? 32'd0 : pcnt_q + 32'd1;
    end

    if (wrCtrl) begin
      ctrl_d = Byte_Enable[0] ? wData[2:0] : ctrl_q;
    end else if (hit && !ctrl_q[1]) begin
      ctrl_d = {ctrl_q[2:1], 1'b0};
    end

    if (wrPsc) begin
      psc_d = mergeBytes(psc_q, wData, Byte_Enable);
    end

    if (wrCmp) begin
      cmp_d = mergeBytes(cmp_q, wData, Byte_Enable);
    end

    if (wrCnt) begin
      cnt_d = mergeBytes(cnt_q, wData, Byte_Enable);
    end else if (hit) begin
      cnt_d = ctrl_q[1] ? 32'd0 : cnt_q;
    end else if (tick) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (hit) begin
      match_d = 1'b1;
    end else if (wrStatus && Byte_Enable[0] && wData[0]) begin
      match_d = 1'b0;
    end
  end

  // Register update with asynchronous reset back to the power-on values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= 3'd0;
      psc_q   <= PSC_RESET;
      cnt_q   <= 32'd0;
      cmp_q   <= CMP_RESET;
      match_q <= 1'b0;
      pcnt_q  <= 32'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Zero-wait-state read mux; unselected or unmapped offsets return zero.
  always_comb begin
    rData = 32'd0;
    if (sel) begin
      case (regSel)
        REG_CTRL:   rData = {29'd0, ctrl_q};
        REG_PSC:    rData = psc_q;
        REG_CNT:    rData = cnt_q;
        REG_CMP:    rData = cmp_q;
        REG_STATUS: rData = {31'd0, match_q};
        default:    rData = 32'd0;
      endcase
    end
  end

endmodule
